ts_packetizer: RTL and testbench

Downstream of the pulse timestamp FIFO, in the `ts_strm_clk` domain. Accepts 32-bit timestamp words `{line_id[2:0], ts[28:0]}` and groups them into AXI-Stream packets of `PKT_LEN` words with `TLAST` for the DMA. A partial packet is closed by an idle timeout. Optionally, a marker word is inserted when the 29-bit timestamp wraps.

---
 rtl/ts_packetizer.sv | 155 +++++++++++++++
 tb/tb_ts_packetizer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_packetizer.sv
// Groups {line_id, ts} timestamp words into PKT_LEN-word AXI-Stream packets and closes partial packets after an idle timeout.
// Optional build macro TS_WRAP_MARKER_EN inserts a marker word (32'hE000_0000) ahead of any word whose ts wrapped.
module ts_packetizer #(
    parameter int PKT_LEN = 64,
    parameter int TIMEOUT = 1000000
) (
    input  logic        ts_strm_clk,
    input  logic        resetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] pkt_count,
    output logic [15:0] wrap_count
);
    localparam int CNT_W  = $clog2(PKT_LEN);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0]       MARKER   = 32'hE000_0000;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PKT_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_MARK} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       hold_data_reg, hold_data_next;
    logic [31:0]       pend_data_reg, pend_data_next;
    logic [31:0]       o_data_reg;
    logic              o_valid_reg;
    logic              o_last_reg;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDLE_W-1:0] idle_reg, idle_next;
    logic [15:0]       pkt_count_reg;

    logic o_free;
    logic accept;
    logic is_wrap;
    logic load_o;
    logic load_last;

    assign o_free        = !o_valid_reg || m_axis_tready;
    assign s_axis_tready = (state_reg == ST_EMPTY) || (state_reg == ST_HOLD && o_free);
    assign accept        = s_axis_tvalid && s_axis_tready;

`ifdef TS_WRAP_MARKER_EN
    logic [28:0] last_ts_reg;
    logic [15:0] wrap_count_reg;

    assign is_wrap    = accept && (s_axis_tdata[28:0] < last_ts_reg);
    assign wrap_count = wrap_count_reg;

    always_ff @(posedge ts_strm_clk or negedge resetn) begin
        if (!resetn) begin
            last_ts_reg    <= '0;
            wrap_count_reg <= '0;
        end else begin
            if (accept)
                last_ts_reg <= s_axis_tdata[28:0];
            if (state_reg == ST_MARK && o_free)
                wrap_count_reg <= wrap_count_reg + 16'd1;
        end
    end
`else
    assign is_wrap    = 1'b0;
    assign wrap_count = 16'd0;
`endif

    always_comb begin
        state_next     = state_reg;
        hold_data_next = hold_data_reg;
        pend_data_next = pend_data_reg;
        load_o         = 1'b0;
        load_last      = 1'b0;
        case (state_reg)
            ST_HOLD: begin
                if (accept) begin
                    load_o    = 1'b1;
                    load_last = (cnt_reg == CNT_MAX);
                end else if (idle_reg >= IDLE_MAX && o_free) begin
                    load_o     = 1'b1;
                    load_last  = 1'b1;
                    state_next = ST_EMPTY;
                end
            end
            ST_MARK: begin
                // Marker leaves first; the wrapped data word follows from P.
                if (o_free) begin
                    load_o         = 1'b1;
                    load_last      = (cnt_reg == CNT_MAX);
                    hold_data_next = pend_data_reg;
                    state_next     = ST_HOLD;
                end
            end
            default: ;
        endcase
        // Accept only happens in EMPTY or HOLD; the incoming word lands the same way in both.
        if (accept) begin
            if (is_wrap) begin
                hold_data_next = MARKER;
                pend_data_next = s_axis_tdata;
                state_next     = ST_MARK;
            end else begin
                hold_data_next = s_axis_tdata;
                state_next     = ST_HOLD;
            end
        end

        cnt_next = cnt_reg;
        if (load_o)
            cnt_next = load_last ? '0 : cnt_reg + 1'b1;

        idle_next = idle_reg;
        if (accept || state_reg == ST_EMPTY)
            idle_next = '0;
        else if (idle_reg < IDLE_MAX)
            idle_next = idle_reg + 1'b1;
    end

    always_ff @(posedge ts_strm_clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_EMPTY;
            hold_data_reg <= '0;
            pend_data_reg <= '0;
            o_data_reg    <= '0;
            o_valid_reg   <= 1'b0;
            o_last_reg    <= 1'b0;
            cnt_reg       <= '0;
            idle_reg      <= '0;
            pkt_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            hold_data_reg <= hold_data_next;
            pend_data_reg <= pend_data_next;
            cnt_reg       <= cnt_next;
            idle_reg      <= idle_next;
            if (load_o) begin
                o_data_reg  <= hold_data_reg;
                o_valid_reg <= 1'b1;
                o_last_reg  <= load_last;
            end else if (m_axis_tready) begin
                o_valid_reg <= 1'b0;
            end
            if (o_valid_reg && m_axis_tready && o_last_reg)
                pkt_count_reg <= pkt_count_reg + 16'd1;
        end
    end

    assign m_axis_tdata  = o_data_reg;
    assign m_axis_tvalid = o_valid_reg;
    assign m_axis_tlast  = o_last_reg;
    assign pkt_count     = pkt_count_reg;

endmodule

// File: tb/tb_ts_packetizer.sv
// Self-checking bench for ts_packetizer: the reference model turns the accepted word stream into the expected packet stream.
// Works with or without TS_WRAP_MARKER_EN defined.
module tb_ts_packetizer;
    localparam int PKT_LEN = 4;
    localparam int TIMEOUT = 10;
    localparam logic [31:0] MARKER = 32'hE000_0000;
`ifdef TS_WRAP_MARKER_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 0;
`endif

    logic        ts_strm_clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [15:0] pkt_count;
    logic [15:0] wrap_count;

    always #5 ts_strm_clk = ~ts_strm_clk;

    ts_packetizer #(.PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT)) dut (
        .ts_strm_clk  (ts_strm_clk),
        .resetn       (resetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .pkt_count    (pkt_count),
        .wrap_count   (wrap_count)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_d[$];
    logic [31:0] obs_d[$];
    bit          exp_l[$];
    bit          obs_l[$];
    int          m_pos = 0;
    logic [28:0] m_last_ts = '0;
    int          exp_pkts = 0;
    int          exp_wraps = 0;
    logic [28:0] gen_ts = '0;
    bit          rand_rdy = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Packet view of the output: positions count every word (markers too); a packet ends every PKT_LEN words.
    function automatic void model_push(input logic [31:0] d);
        bit last;
        last = (m_pos == PKT_LEN - 1);
        exp_d.push_back(d);
        exp_l.push_back(last);
        if (last) begin
            m_pos = 0;
            exp_pkts++;
        end else begin
            m_pos++;
        end
    endfunction

    function automatic void model_accept(input logic [31:0] w);
`ifdef TS_WRAP_MARKER_EN
        if (w[28:0] < m_last_ts) begin
            model_push(MARKER);
            exp_wraps++;
        end
`endif
        m_last_ts = w[28:0];
        model_push(w);
    endfunction

    // An idle timeout closes whatever partial packet is open.
    function automatic void model_flush();
        if (m_pos != 0) begin
            exp_l[exp_l.size()-1] = 1'b1;
            exp_pkts++;
            m_pos = 0;
        end
    endfunction

    function automatic void model_reset();
        exp_d.delete(); exp_l.delete(); obs_d.delete(); obs_l.delete();
        m_pos = 0; m_last_ts = '0; exp_pkts = 0; exp_wraps = 0;
    endfunction

    function automatic logic [31:0] gen_word(input bit allow_wrap);
        logic [28:0] ts;
        if (allow_wrap && gen_ts > 0 && $urandom_range(0, 7) == 0)
            ts = 29'($urandom_range(0, 32'(gen_ts) - 1));
        else
            ts = gen_ts + 29'($urandom_range(1, 50));
        gen_ts = ts;
        return {3'($urandom_range(0, 6)), ts};
    endfunction

    always @(negedge ts_strm_clk) begin
        if (resetn) begin
            if (s_axis_tvalid && s_axis_tready)
                model_accept(s_axis_tdata);
            if (m_axis_tvalid && m_axis_tready) begin
                obs_d.push_back(m_axis_tdata);
                obs_l.push_back(m_axis_tlast);
            end
        end
    end

    task automatic step();
        @(posedge ts_strm_clk);
        #1;
        if (rand_rdy)
            m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_word(input logic [31:0] w, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        while (!done) begin
            @(negedge ts_strm_clk);
            if (s_axis_tready) begin
                done = 1'b1;
            end else if (stalls == 200) begin
                check_val("accept_bound", 32'(stalls), 32'd0);
                done = 1'b1;
            end else begin
                stalls++;
            end
            step();
        end
    endtask

    task automatic end_phase();
        s_axis_tvalid = 1'b0;
        rand_rdy      = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3 * TIMEOUT + 10) step();
        model_flush();
        check_val("n_words", 32'(obs_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            check_val($sformatf("tdata[%0d]", i), obs_d[i], exp_d[i]);
            check_val($sformatf("tlast[%0d]", i), 32'(obs_l[i]), 32'(exp_l[i]));
        end
        check_val("pkt_count", 32'(pkt_count), 32'(exp_pkts[15:0]));
        check_val("wrap_count", 32'(wrap_count), 32'(exp_wraps[15:0]));
        exp_d.delete(); exp_l.delete(); obs_d.delete(); obs_l.delete();
    endtask

    initial begin
        int          st;
        int          n;
        int          acc;
        bit          stable;
        bit          seen;
        bit          nxt;
        logic [31:0] w;
        logic [31:0] o_hold;
        logic        l_hold;
        logic [15:0] pb;

        o_hold = '0;
        l_hold = 1'b0;
        repeat (3) @(posedge ts_strm_clk);
        #1;
        check_val("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check_val("rst_tdata", m_axis_tdata, 32'd0);
        check_val("rst_tready", 32'(s_axis_tready), 32'd1);
        check_val("rst_pkt", 32'(pkt_count), 32'd0);
        check_val("rst_wrap", 32'(wrap_count), 32'd0);
        @(negedge ts_strm_clk);
        resetn = 1'b1;
        step();

        // Lone word: must appear with tlast exactly TIMEOUT+1 cycles after acceptance.
        drive_word(32'h0000_0005, st);
        gen_ts = 29'd5;
        s_axis_tvalid = 1'b0;
        check_val("lat_pre", 32'(m_axis_tvalid), 32'd0);
        n = 0;
        while (!m_axis_tvalid && n < 50) begin
            step();
            n++;
        end
        check_val("lat_cycles", 32'(n), 32'(TIMEOUT + 1));
        check_val("lat_data", m_axis_tdata, 32'h0000_0005);
        check_val("lat_last", 32'(m_axis_tlast), 32'd1);
        end_phase();

        // Nine back-to-back words: two full packets plus one closed by timeout.
        pb = pkt_count;
        for (int i = 0; i < 9; i++) drive_word(gen_word(1'b0), st);
        end_phase();
        check_val("pkt9", 32'(16'(pkt_count - pb)), 32'd3);

        // Output stalled for 20 cycles starting from an empty pipeline.
        m_axis_tready = 1'b0;
        w = gen_word(1'b0);
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        acc = 0; stable = 1'b1; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ts_strm_clk);
            nxt = s_axis_tready;
            if (nxt) acc++;
            if (m_axis_tvalid) begin
                if (!seen) begin
                    seen = 1'b1; o_hold = m_axis_tdata; l_hold = m_axis_tlast;
                end else if (m_axis_tdata !== o_hold || m_axis_tlast !== l_hold) begin
                    stable = 1'b0;
                end
            end
            step();
            if (nxt) begin
                w = gen_word(1'b0);
                s_axis_tdata = w;
            end
        end
        check_val("bp_accepts", 32'(acc), 32'd2);
        check_val("bp_tready", 32'(s_axis_tready), 32'd0);
        check_val("bp_seen", 32'(seen), 32'd1);
        check_val("bp_stable", 32'(stable), 32'd1);
        m_axis_tready = 1'b1;
        drive_word(w, st);
        for (int i = 0; i < 5; i++) drive_word(gen_word(1'b0), st);
        end_phase();

        // Timestamp wrap: marker (when built in) costs one input bubble.
        drive_word(32'h1FFF_FFFE, st);
        drive_word(32'h0000_0003, st);
        drive_word(32'h0000_000A, st);
        check_val("wrap_stall", 32'(st), 32'(EXP_STALL));
        gen_ts = 29'd10;
        end_phase();

        // Continuous input against random output backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) drive_word(gen_word(1'b1), st);
        end_phase();

        // Short random input gaps (well below the timeout) with a free output.
        for (int i = 0; i < 300; i++) begin
            drive_word(gen_word(1'b1), st);
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(0, 3)) step();
        end
        end_phase();

        // Reset in the middle of a packet discards it.
        m_axis_tready = 1'b0;
        drive_word(gen_word(1'b0), st);
        drive_word(gen_word(1'b0), st);
        s_axis_tvalid = 1'b0;
        resetn = 1'b0;
        #1;
        check_val("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("mrst_tlast", 32'(m_axis_tlast), 32'd0);
        check_val("mrst_tdata", m_axis_tdata, 32'd0);
        check_val("mrst_tready", 32'(s_axis_tready), 32'd1);
        check_val("mrst_pkt", 32'(pkt_count), 32'd0);
        check_val("mrst_wrap", 32'(wrap_count), 32'd0);
        model_reset();
        repeat (2) step();
        @(negedge ts_strm_clk);
        resetn = 1'b1;
        m_axis_tready = 1'b1;
        step();
        for (int i = 0; i < 6; i++) drive_word(gen_word(1'b0), st);
        end_phase();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
